// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, load/store and memory-side signals of the unified memory arbiter
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;
  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W/8-1:0] d_wstrb;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_we, d_addr, d_wdata, d_wstrb,
           mem_ack, mem_rvalid, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output if_req_valid, if_addr, d_req_valid, d_we, d_addr, d_wdata, d_wstrb,
           mem_ack, mem_rvalid, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: one-at-a-time sharing of a single-port memory, data first with a fetch starvation bound
module unified_mem_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic                  clk,
  input logic                  rst,
  unified_mem_arbiter_if.slave bus
);
  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(MAX_DATA_STREAK + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     streak_q, streak_d;
  logic              owner_q, owner_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic              if_rsp_q, if_rsp_d, d_rsp_q, d_rsp_d;
  logic              idle, fetch_win, data_win, grant, done, at_max;
  always_comb begin
    idle      = state_q == IDLE && !rst;
    at_max    = streak_q == CW'(MAX_DATA_STREAK);
    fetch_win = bus.if_req_valid && (!bus.d_req_valid || at_max);
    data_win  = bus.d_req_valid && !fetch_win;
    grant     = idle && (fetch_win || data_win);
    done      = bus.mem_rvalid && (state_q == WAIT || (state_q == ISSUE && bus.mem_ack));
    state_d   = grant ? ISSUE : done ? IDLE : (state_q == ISSUE && bus.mem_ack) ? WAIT : state_q;
    owner_d   = grant ? data_win : owner_q;
    we_d      = grant ? data_win && bus.d_we : we_q;
    addr_d    = grant ? (data_win ? bus.d_addr : bus.if_addr) : addr_q;
    wdata_d   = grant ? (data_win ? bus.d_wdata : '0) : wdata_q;
    wstrb_d   = grant ? (data_win && bus.d_we ? bus.d_wstrb : '0) : wstrb_q;
    streak_d  = !grant ? streak_q :
                (data_win && bus.if_req_valid) ? (at_max ? streak_q : streak_q + 1'b1) : '0;
    if_rsp_d  = done && !owner_q;
    d_rsp_d   = done && owner_q;
    if_rdata_d = if_rsp_d ? bus.mem_rdata : if_rdata_q;
    d_rdata_d  = d_rsp_d ? (we_q ? '0 : bus.mem_rdata) : d_rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      if_rsp_q   <= 1'b0;
      d_rsp_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      if_rsp_q   <= if_rsp_d;
      d_rsp_q    <= d_rsp_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
  assign bus.if_req_ready = idle && fetch_win;
  assign bus.d_req_ready  = idle && data_win;
  assign bus.if_rsp_valid = if_rsp_q;
  assign bus.if_rsp_data  = if_rdata_q;
  assign bus.d_rsp_valid  = d_rsp_q;
  assign bus.d_rsp_rdata  = d_rdata_q;
  assign bus.mem_req      = state_q == ISSUE;
  assign bus.mem_we       = we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_wstrb    = wstrb_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: vector table plus corner sequences, responses checked through per-port scoreboards
module tb_unified_mem_arbiter;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic [31:0] exp;} req_t;
  typedef struct {logic [31:0] exp; int gcyc; int lat;} sb_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} iss_t;
  typedef struct {bit is_d; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
                  int ack; int rv; logic [31:0] exp;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  req_t fq[$];
  req_t dq[$];
  sb_t fsb[$];
  sb_t dsb[$];
  iss_t iq[$];
  byte glog[$];
  int gq[$];
  int tests = 0, fails = 0, cyc = 0;
  int ack_dly = 0, rv_dly = 1;
  bit auto_rsp = 1'b1, f_busy = 1'b0, d_busy = 1'b0;
  logic man_ack = 1'b0, man_rv = 1'b0;
  logic [31:0] man_data = '0;
  logic [31:0] mem [256];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // fetch requester: holds valid and address until ready is seen
  initial begin
    req_t r;
    bus.if_req_valid = 1'b0;
    bus.if_addr = '0;
    forever begin
      @(negedge clk);
      if (!f_busy) begin
        if (fq.size() > 0) begin
          r = fq.pop_front();
          bus.if_addr = r.addr;
          bus.if_req_valid = 1'b1;
          f_busy = 1'b1;
        end else bus.if_req_valid = 1'b0;
      end
      #1;
      if (f_busy && bus.if_req_ready) begin
        fsb.push_back('{r.exp, cyc, 2 + ack_dly + rv_dly});
        iq.push_back('{1'b0, r.addr, 32'h0, 4'h0});
        glog.push_back("I");
        gq.push_back(cyc);
        f_busy = 1'b0;
      end
    end
  end
  initial begin
    req_t r;
    bus.d_req_valid = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.d_wstrb = '0;
    forever begin
      @(negedge clk);
      if (!d_busy) begin
        if (dq.size() > 0) begin
          r = dq.pop_front();
          bus.d_we = r.we;
          bus.d_addr = r.addr;
          bus.d_wdata = r.wdata;
          bus.d_wstrb = r.wstrb;
          bus.d_req_valid = 1'b1;
          d_busy = 1'b1;
        end else bus.d_req_valid = 1'b0;
      end
      #1;
      if (d_busy && bus.d_req_ready) begin
        dsb.push_back('{r.exp, cyc, 2 + ack_dly + rv_dly});
        iq.push_back('{r.we, r.addr, r.wdata, r.we ? r.wstrb : 4'h0});
        glog.push_back("D");
        gq.push_back(cyc);
        d_busy = 1'b0;
      end
    end
  end
  // memory macro model with programmable ack and response delays
  initial begin
    int acnt, rcnt;
    bit busy;
    logic [31:0] held;
    iss_t e;
    acnt = 0;
    rcnt = 0;
    busy = 1'b0;
    held = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (rst) begin
        acnt = 0;
        busy = 1'b0;
      end else if (!auto_rsp) begin
        bus.mem_ack = man_ack;
        bus.mem_rvalid = man_rv;
        bus.mem_rdata = man_data;
      end else if (busy) begin
        if (rcnt >= rv_dly) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = held;
          busy = 1'b0;
        end else rcnt++;
      end else if (bus.mem_req) begin
        check("readies_while_busy", 32'({bus.if_req_ready, bus.d_req_ready}), 32'h0);
        if (iq.size() == 0) check("mem_req_without_grant", 32'(bus.mem_req), 32'h0);
        else begin
          e = iq[0];
          check("mem_we", 32'(bus.mem_we), 32'(e.we));
          check("mem_addr", bus.mem_addr, e.addr);
          check("mem_wstrb", 32'(bus.mem_wstrb), 32'(e.wstrb));
          if (e.we) check("mem_wdata", bus.mem_wdata, e.wdata);
          if (acnt >= ack_dly) begin
            void'(iq.pop_front());
            acnt = 0;
            bus.mem_ack = 1'b1;
            held = bus.mem_we ? 32'hFFFF_FFFF : mem[bus.mem_addr[9:2]];
            if (bus.mem_we)
              for (int b = 0; b < 4; b++)
                if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
            if (rv_dly == 0) begin
              bus.mem_rvalid = 1'b1;
              bus.mem_rdata = held;
            end else begin
              busy = 1'b1;
              rcnt = 1;
            end
          end else acnt++;
        end
      end
    end
  end
  initial begin
    sb_t s;
    forever begin
      @(negedge clk);
      if (bus.if_rsp_valid) begin
        if (fsb.size() == 0) check("if_rsp_unexpected", 32'(bus.if_rsp_valid), 32'h0);
        else begin
          s = fsb.pop_front();
          check("if_rsp_data", bus.if_rsp_data, s.exp);
          check("if_rsp_latency", 32'(cyc - s.gcyc), 32'(s.lat));
        end
      end
      if (bus.d_rsp_valid) begin
        if (dsb.size() == 0) check("d_rsp_unexpected", 32'(bus.d_rsp_valid), 32'h0);
        else begin
          s = dsb.pop_front();
          check("d_rsp_rdata", bus.d_rsp_rdata, s.exp);
          check("d_rsp_latency", 32'(cyc - s.gcyc), 32'(s.lat));
        end
      end
    end
  end
  task automatic drain(input string name);
    int n = 0;
    while ((fq.size() > 0 || dq.size() > 0 || f_busy || d_busy || fsb.size() > 0 || dsb.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n >= 300), 32'h0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t vt[9];
    string order;
    int base;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5C3_0000 + i;
    mem[16] = 32'h0050_0093;
    mem[17] = 32'h0010_0113;
    mem[64] = 32'h1122_3344;
    mem[65] = 32'h5566_7788;
    mem[66] = 32'h0000_0000;
    vt[0] = '{1'b0, 1'b0, 32'h40,  32'h0,         4'h0, 0, 1, 32'h0050_0093};
    vt[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3, 0, 1, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h100, 32'h0,         4'h0, 0, 0, 32'h1122_BEEF};
    vt[3] = '{1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, 4'h0, 1, 2, 32'h0};
    vt[4] = '{1'b1, 1'b0, 32'h104, 32'h0,         4'h0, 2, 0, 32'h5566_7788};
    vt[5] = '{1'b1, 1'b1, 32'h108, 32'hA5A5_A5A5, 4'hC, 0, 0, 32'h0};
    vt[6] = '{1'b1, 1'b0, 32'h108, 32'h0,         4'h0, 0, 1, 32'hA5A5_0000};
    vt[7] = '{1'b0, 1'b0, 32'h44,  32'h0,         4'h0, 0, 0, 32'h0010_0113};
    vt[8] = '{1'b1, 1'b0, 32'h200, 32'h0,         4'h0, 3, 1, 32'hA5C3_0080};
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_rsp_valid", 32'({bus.if_rsp_valid, bus.d_rsp_valid}), 32'h0);
    check("rst_if_rsp_data", bus.if_rsp_data, 32'h0);
    check("rst_d_rsp_rdata", bus.d_rsp_rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ack_dly = vt[i].ack;
      rv_dly = vt[i].rv;
      if (vt[i].is_d) dq.push_back('{vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wstrb, vt[i].exp});
      else fq.push_back('{1'b0, vt[i].addr, 32'h0, 4'h0, vt[i].exp});
      drain($sformatf("vec%0d", i));
    end
    // ack with rvalid in the same cycle: grants every two cycles
    ack_dly = 0;
    rv_dly = 0;
    gq.delete();
    for (int k = 1; k < 4; k++) dq.push_back('{1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'h0, 32'hA5C3_0080 + 32'(k)});
    drain("b2b");
    check("b2b_grants", 32'(gq.size()), 32'd3);
    for (int k = 1; k < gq.size(); k++) check("b2b_gap", 32'(gq[k] - gq[k-1]), 32'd2);
    rv_dly = 1;
    glog.delete();
    gq.delete();
    fq.push_back('{1'b0, 32'h40, 32'h0, 4'h0, 32'h0050_0093});
    fq.push_back('{1'b0, 32'h44, 32'h0, 4'h0, 32'h0010_0113});
    for (int k = 0; k < 8; k++) dq.push_back('{1'b0, 32'h200 + 32'(4 * k), 32'h0, 4'h0, 32'hA5C3_0080 + 32'(k)});
    drain("streak");
    order = "DDDDIDDDDI";
    check("streak_grants", 32'(glog.size()), 32'd10);
    for (int k = 0; k < 10 && k < glog.size(); k++) check($sformatf("streak_order%0d", k), 32'(glog[k]), 32'(order[k]));
    for (int k = 1; k < gq.size(); k++) check("streak_gap", 32'(gq[k] - gq[k-1]), 32'd3);
    ack_dly = 10;
    dq.push_back('{1'b1, 32'h10C, 32'h1234_5678, 4'hF, 32'h0});
    fq.push_back('{1'b0, 32'h40, 32'h0, 4'h0, 32'h0050_0093});
    drain("stall");
    check("stall_store_landed", mem[67], 32'h1234_5678);
    // reset while waiting for the read data, then a stale rvalid
    ack_dly = 0;
    auto_rsp = 1'b0;
    fq.push_back('{1'b0, 32'h44, 32'h0, 4'h0, 32'h0010_0113});
    base = 0;
    do begin
      @(negedge clk);
      #2;
      base++;
    end while (!bus.mem_req && base < 20);
    check("rstwait_req_seen", 32'(bus.mem_req), 32'h1);
    man_ack = 1'b1;
    @(negedge clk);
    #2;
    man_ack = 1'b0;
    @(negedge clk);
    #2;
    check("rstwait_in_wait", 32'(bus.mem_req), 32'h0);
    rst = 1'b1;
    #1;
    check("rstwait_if_data", bus.if_rsp_data, 32'h0);
    check("rstwait_d_data", bus.d_rsp_rdata, 32'h0);
    check("rstwait_outs", 32'({bus.mem_req, bus.if_rsp_valid, bus.d_rsp_valid, bus.if_req_ready, bus.d_req_ready}), 32'h0);
    fsb.delete();
    dsb.delete();
    iq.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    man_rv = 1'b1;
    man_data = 32'hDEAD_DEAD;
    @(negedge clk);
    #2;
    man_rv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #2;
      check("stale_no_rsp", 32'({bus.if_rsp_valid, bus.d_rsp_valid, bus.mem_req}), 32'h0);
    end
    auto_rsp = 1'b1;
    dq.push_back('{1'b0, 32'h100, 32'h0, 4'h0, 32'h1122_BEEF});
    drain("after_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
